encoder_sequencer: RTL and testbench

- Clocked controller that shares one Codificador nibble encoder between two requesters.
- Round-robin arbitration between the requesters; drives the encoder's A/B/C/D inputs, its `ready` strobe and its active-high `reset`.
- Captures the 4-bit codeword S0..S3 and returns it with owner tag and valid pulse.
- Sits between the nibble producers and the encoder instance.

---
 rtl/encoder_sequencer.sv | 157 +++++++++++++++
 tb/tb_encoder_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/encoder_sequencer.sv
// encoder_sequencer: shares one Codificador nibble encoder between two
// requesters with round-robin arbitration, sequences the encoder strobes and
// returns the captured codeword tagged with its owner.
// Optional build macro: ENCODER_CLEAR_EN inserts a one-cycle encoder clear
// (CLEAR state) between each grant and its settle phase.
module encoder_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [3:0] req0_nibble,
  output logic       req0_grant,
  input  logic       req1_valid,
  input  logic [3:0] req1_nibble,
  output logic       req1_grant,
  output logic       enc_a,
  output logic       enc_b,
  output logic       enc_c,
  output logic       enc_d,
  output logic       enc_ready,
  output logic       enc_reset,
  input  logic [3:0] enc_s,
  output logic [3:0] code_out,
  output logic       code_owner,
  output logic       code_valid,
  output logic       busy
);

  // A settle time of zero is not meaningful; the encoder always gets one cycle.
  localparam int unsigned SETTLE_EFF = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
  localparam int unsigned CNT_W      = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_EFF - 1);

  typedef enum logic [2:0] {
    INIT    = 3'd0,
    IDLE    = 3'd1,
    CLEAR   = 3'd2,
    SETUP   = 3'd3,
    STROBE  = 3'd4,
    CAPTURE = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             grant0;
  logic             grant1;
  logic             last_grant;
  logic             owner;
  logic [3:0]       enc_nib;
  logic             enc_reset_next;

  // The grants are decided and pulsed in the IDLE cycle that accepts a request.
  assign req0_grant = grant0;
  assign req1_grant = grant1;

  assign enc_a = enc_nib[3];
  assign enc_b = enc_nib[2];
  assign enc_c = enc_nib[1];
  assign enc_d = enc_nib[0];

  // State register; reset forces INIT so the encoder gets its clear pulse.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= INIT;
    end else begin
      state <= next_state;
    end
  end

  // Next-state, settle counter and round-robin grant decision.
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    grant0     = 1'b0;
    grant1     = 1'b0;
    unique case (state)
      INIT: next_state = IDLE;
      IDLE: begin
        if (req0_valid || req1_valid) begin
          // On contention the requester that did not win last time goes first.
          if (req0_valid && (!req1_valid || last_grant)) begin
            grant0 = 1'b1;
          end else begin
            grant1 = 1'b1;
          end
          cnt_next = '0;
`ifdef ENCODER_CLEAR_EN
          next_state = CLEAR;
`else
          next_state = SETUP;
`endif
        end
      end
`ifdef ENCODER_CLEAR_EN
      CLEAR: next_state = SETUP;
`endif
      SETUP: begin
        if (cnt == CNT_LAST) begin
          next_state = STROBE;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      STROBE:  next_state = CAPTURE;
      CAPTURE: next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = INIT;
    endcase
    // Reset aborts any conversion and suppresses a same-cycle grant.
    if (!reset) begin
      next_state = INIT;
      grant0     = 1'b0;
      grant1     = 1'b0;
    end
  end

  // Encoder clear is driven in INIT and, when built in, in CLEAR.
  always_comb begin
    enc_reset_next = (next_state == INIT);
`ifdef ENCODER_CLEAR_EN
    if (next_state == CLEAR) begin
      enc_reset_next = 1'b1;
    end
`endif
  end

  // Registered strobes derived from the upcoming state, plus the datapath.
  always_ff @(posedge clock) begin
    cnt        <= cnt_next;
    enc_ready  <= (next_state == STROBE);
    enc_reset  <= enc_reset_next;
    code_valid <= (next_state == DONE);
    busy       <= (next_state != IDLE);
    if (!reset) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      enc_nib    <= 4'b0000;
      code_out   <= 4'b0000;
      code_owner <= 1'b0;
    end else begin
      if (grant0 || grant1) begin
        last_grant <= grant1;
        owner      <= grant1;
        enc_nib    <= grant1 ? req1_nibble : req0_nibble;
      end
      if (state == CAPTURE) begin
        code_out   <= enc_s;
        code_owner <= owner;
      end
    end
  end

endmodule

// File: tb/tb_encoder_sequencer.sv
// Directed bench for encoder_sequencer with a behavioural Codificador model.
// Build with ENCODER_CLEAR_EN defined to exercise the clear-per-conversion build.
module tb_encoder_sequencer;

  localparam int S = 2;
`ifdef ENCODER_CLEAR_EN
  localparam int CLR = 1;
`else
  localparam int CLR = 0;
`endif
  localparam int L_READY = S + 1 + CLR;
  localparam int L_VALID = S + 3 + CLR;
  localparam int SPACING = S + 4 + CLR;

  logic       clock;
  logic       reset;
  logic       req0_valid;
  logic [3:0] req0_nibble;
  logic       req0_grant;
  logic       req1_valid;
  logic [3:0] req1_nibble;
  logic       req1_grant;
  logic       enc_a, enc_b, enc_c, enc_d;
  logic       enc_ready;
  logic       enc_reset;
  logic [3:0] enc_s;
  logic [3:0] code_out;
  logic       code_owner;
  logic       code_valid;
  logic       busy;

  int tests;
  int fails;
  int overlap;

  encoder_sequencer #(.SETTLE_CYCLES(S)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_nibble(req0_nibble), .req0_grant(req0_grant),
    .req1_valid(req1_valid), .req1_nibble(req1_nibble), .req1_grant(req1_grant),
    .enc_a(enc_a), .enc_b(enc_b), .enc_c(enc_c), .enc_d(enc_d),
    .enc_ready(enc_ready), .enc_reset(enc_reset), .enc_s(enc_s),
    .code_out(code_out), .code_owner(code_owner), .code_valid(code_valid),
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Encoder model: known codewords for the nibbles used here.
  function automatic logic [3:0] enc_model(input logic [3:0] n);
    case (n)
      4'b0000: return 4'b0101;
      4'b0001: return 4'b1100;
      4'b1010: return 4'b1101;
      default: return 4'b1111;
    endcase
  endfunction

  always @(posedge enc_ready or posedge enc_reset) begin
    if (enc_reset) enc_s <= 4'b0000;
    else           enc_s <= enc_model({enc_a, enc_b, enc_c, enc_d});
  end

  always @(negedge clock) begin
    if (enc_ready === 1'b1 && enc_reset === 1'b1) overlap++;
  end

  task automatic wait_idle();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clock);
      if (busy === 1'b0) seen = 1'b1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL wait_idle: busy=%b still high after 50 cycles, required 0", busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      @(negedge clock);
      tests++;
      if ({enc_a, enc_b, enc_c, enc_d, enc_ready, enc_reset, code_out, code_owner,
           code_valid, req0_grant, req1_grant, busy} !== 15'b0000_0_1_0000_0_0_0_0_1) begin
        fails++;
        $display("FAIL reset_values cyc%0d: pins=%b%b%b%b rdy=%b rst=%b code=%b own=%b vld=%b g=%b%b busy=%b",
                 c, enc_a, enc_b, enc_c, enc_d, enc_ready, enc_reset, code_out, code_owner,
                 code_valid, req0_grant, req1_grant, busy);
      end
    end
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    tests++;
    if ({enc_reset, busy} !== 2'b11) begin
      fails++;
      $display("FAIL init_cycle: enc_reset,busy=%b required 11", {enc_reset, busy});
    end
    @(posedge clock); #1;
    @(negedge clock);
    tests++;
    if ({enc_reset, busy, enc_ready} !== 3'b000) begin
      fails++;
      $display("FAIL idle_after_init: enc_reset,busy,enc_ready=%b required 000",
               {enc_reset, busy, enc_ready});
    end
  endtask

  // One request from an idle sequencer, checking every cycle to the code_valid.
  task automatic run_req(input logic who, input logic [3:0] nib, input logic [3:0] exp_code,
                         input logic [3:0] prev_code, input string name);
    wait_idle();
    @(posedge clock); #1;
    if (who) begin req1_valid = 1'b1; req1_nibble = nib; end
    else     begin req0_valid = 1'b1; req0_nibble = nib; end
    @(negedge clock);
    tests++;
    if ({req0_grant, req1_grant} !== (who ? 2'b01 : 2'b10)) begin
      fails++;
      $display("FAIL %s grant: got %b%b required %b", name, req0_grant, req1_grant,
               who ? 2'b01 : 2'b10);
    end
    for (int k = 1; k <= L_VALID + 1; k++) begin
      @(posedge clock); #1;
      if (k == 1) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      @(negedge clock);
      tests++;
      if ({enc_ready, enc_reset, code_valid, req0_grant, req1_grant, busy} !==
          {k == L_READY, (CLR == 1) && (k == 1), k == L_VALID, 2'b00, k <= L_VALID}) begin
        fails++;
        $display("FAIL %s seq t+%0d: rdy=%b rst=%b vld=%b g=%b%b busy=%b", name, k,
                 enc_ready, enc_reset, code_valid, req0_grant, req1_grant, busy);
      end
      if (k <= L_READY + 1 && {enc_a, enc_b, enc_c, enc_d} !== nib) begin
        fails++;
        $display("FAIL %s pins t+%0d: got %b%b%b%b required %b", name, k,
                 enc_a, enc_b, enc_c, enc_d, nib);
      end
      if (k < L_VALID && code_out !== prev_code) begin
        fails++;
        $display("FAIL %s code_hold t+%0d: got %b required %b", name, k, code_out, prev_code);
      end
      if (k == L_VALID) begin
        tests++;
        if ({code_out, code_owner} !== {exp_code, who}) begin
          fails++;
          $display("FAIL %s codeword: got %b owner %b required %b owner %b", name,
                   code_out, code_owner, exp_code, who);
        end
      end
    end
  endtask

  task automatic test_basic();
    run_req(1'b0, 4'b0000, 4'b0101, 4'b0000, "req0_0000");
  endtask

  task automatic test_codes();
    run_req(1'b0, 4'b1010, 4'b1101, 4'b0101, "req0_1010");
    run_req(1'b1, 4'b0001, 4'b1100, 4'b1101, "req1_0001");
  endtask

  task automatic test_back_to_back();
    int   last_cyc;
    int   ngr;
    int   busy_grant;
    logic exp_who;
    wait_idle();
    @(posedge clock); #1;
    req0_valid = 1'b1; req0_nibble = 4'b0000;
    req1_valid = 1'b1; req1_nibble = 4'b0001;
    ngr = 0; last_cyc = 0; busy_grant = 0; exp_who = 1'b0;
    for (int c = 0; c < 4 * SPACING && ngr < 4; c++) begin
      if (c > 0) begin @(posedge clock); #1; end
      @(negedge clock);
      if (busy && (req0_grant || req1_grant)) busy_grant++;
      if (code_valid) begin
        tests++;
        if (code_out !== (code_owner ? 4'b1100 : 4'b0101)) begin
          fails++;
          $display("FAIL b2b codeword: got %b for owner %b", code_out, code_owner);
        end
      end
      if (req0_grant || req1_grant) begin
        tests++;
        if ({req0_grant, req1_grant} !== (exp_who ? 2'b01 : 2'b10)) begin
          fails++;
          $display("FAIL b2b order grant%0d: got %b%b required owner %b", ngr,
                   req0_grant, req1_grant, exp_who);
        end
        if (ngr > 0) begin
          tests++;
          if (c - last_cyc != SPACING) begin
            fails++;
            $display("FAIL b2b spacing grant%0d: got %0d required %0d", ngr, c - last_cyc, SPACING);
          end
        end
        last_cyc = c;
        ngr++;
        exp_who = ~exp_who;
      end
    end
    @(posedge clock); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    tests++;
    if (ngr != 4) begin
      fails++;
      $display("FAIL b2b grant_count: got %0d required 4", ngr);
    end
    tests++;
    if (busy_grant != 0) begin
      fails++;
      $display("FAIL b2b grant_while_busy: got %0d required 0", busy_grant);
    end
    wait_idle();
  endtask

  task automatic test_reset_abort();
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    wait_idle();
    @(posedge clock); #1;
    req1_valid = 1'b1; req1_nibble = 4'b0001;
    for (int k = 1; k <= L_READY + 4; k++) begin
      @(posedge clock); #1;
      if (k == 1) req1_valid = 1'b0;
      if (k == L_READY) reset = 1'b0;
      if (k == L_READY + 1) reset = 1'b1;
      @(negedge clock);
      tests++;
      if ({code_valid, code_out} !== 5'b0_0000) begin
        fails++;
        $display("FAIL abort no_capture t+%0d: vld=%b code=%b required 0/0000", k, code_valid, code_out);
      end
      if (k == L_READY) begin
        tests++;
        if ({enc_ready, req0_grant, req1_grant} !== 3'b100) begin
          fails++;
          $display("FAIL abort strobe: rdy,g=%b required 100", {enc_ready, req0_grant, req1_grant});
        end
      end
      if (k == L_READY + 1) begin
        tests++;
        if ({enc_ready, enc_reset, busy} !== 3'b011) begin
          fails++;
          $display("FAIL abort init: rdy,rst,busy=%b required 011", {enc_ready, enc_reset, busy});
        end
      end
      if (k == L_READY + 2) begin
        tests++;
        if ({enc_ready, enc_reset, busy} !== 3'b000) begin
          fails++;
          $display("FAIL abort idle: rdy,rst,busy=%b required 000", {enc_ready, enc_reset, busy});
        end
      end
    end
    run_req(1'b1, 4'b0001, 4'b1100, 4'b0000, "after_abort");
  endtask

  task automatic test_exclusive_strobes();
    tests++;
    if (overlap != 0) begin
      fails++;
      $display("FAIL ready_reset_overlap: got %0d cycles required 0", overlap);
    end
  endtask

  initial begin
    tests = 0; fails = 0; overlap = 0;
    reset = 1'b0;
    req0_valid = 1'b0; req0_nibble = 4'b0000;
    req1_valid = 1'b0; req1_nibble = 4'b0000;
    test_reset();
    test_basic();
    test_codes();
    test_back_to_back();
    test_reset_abort();
    test_exclusive_strobes();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
